// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: shares one prescaled countdown timer between two
// requesters. Round-robin arbitration latches the winner's unit count, a
// prescaler divides the clock into unit ticks, and the owner receives a
// one-cycle done pulse when its count reaches zero. All outputs are registered.

module shared_timer_arbiter #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1000,
  parameter int PW       = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] count0,
  input  logic [WIDTH-1:0] count1,
  input  logic [1:0]       cancel,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] remaining,
  output logic             unit_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [PW-1:0]    PS_ZERO  = PW'(0);
  localparam logic [PW-1:0]    PS_ONE   = PW'(1);
  localparam logic [PW-1:0]    PS_MAX   = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_r, state_s;
  logic [1:0]       grant_r, grant_s;
  logic             busy_r, busy_s;
  logic [1:0]       done_r, done_s;
  logic [WIDTH-1:0] remaining_r, remaining_s;
  logic             unit_tick_r, unit_tick_s;
  logic [PW-1:0]    prescaler_r, prescaler_s;
  // Index of the requester served most recently; the other one wins a tie.
  logic             last_served_r, last_served_s;
  logic             winner_s;
  logic [WIDTH-1:0] won_count_s;

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_r       <= 2'b00;
      busy_r        <= 1'b0;
      done_r        <= 2'b00;
      remaining_r   <= CNT_ZERO;
      unit_tick_r   <= 1'b0;
      prescaler_r   <= PS_ZERO;
      last_served_r <= 1'b1;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      remaining_r   <= remaining_s;
      unit_tick_r   <= unit_tick_s;
      prescaler_r   <= prescaler_s;
      last_served_r <= last_served_s;
    end
  end

  // Next-state and next-output logic: arbitration, prescaling, countdown, cancel.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    busy_s        = busy_r;
    done_s        = 2'b00;
    remaining_s   = remaining_r;
    unit_tick_s   = 1'b0;
    prescaler_s   = prescaler_r;
    last_served_s = last_served_r;
    winner_s      = 1'b0;
    won_count_s   = CNT_ZERO;

    case (state_r)
      IDLE: begin
        grant_s     = 2'b00;
        busy_s      = 1'b0;
        remaining_s = CNT_ZERO;
        prescaler_s = PS_ZERO;
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            winner_s = ~last_served_r;
          end else begin
            winner_s = req[1];
          end
          won_count_s = winner_s ? count1 : count0;
          grant_s     = winner_s ? 2'b10 : 2'b01;
          busy_s      = 1'b1;
          remaining_s = won_count_s;
          if (won_count_s != CNT_ZERO) begin
            state_s = RUN;
          end else begin
            // A zero count completes immediately: done shows with the grant.
            state_s = DONE;
            done_s  = grant_s;
          end
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        if ((cancel & grant_r) != 2'b00) begin
          // Owner abort wins even over a coinciding final decrement.
          state_s       = IDLE;
          grant_s       = 2'b00;
          busy_s        = 1'b0;
          remaining_s   = CNT_ZERO;
          prescaler_s   = PS_ZERO;
          last_served_s = grant_r[1];
        end else if (prescaler_r == PS_MAX) begin
          prescaler_s = PS_ZERO;
          unit_tick_s = 1'b1;
          if (remaining_r != CNT_ZERO) begin
            remaining_s = remaining_r - CNT_ONE;
          end else begin
            remaining_s = CNT_ZERO;
          end
          if (remaining_r <= CNT_ONE) begin
            state_s = DONE;
            done_s  = grant_r;
          end else begin
            state_s = RUN;
          end
        end else begin
          prescaler_s = prescaler_r + PS_ONE;
        end
      end

      DONE: begin
        state_s       = IDLE;
        grant_s       = 2'b00;
        busy_s        = 1'b0;
        prescaler_s   = PS_ZERO;
        last_served_s = grant_r[1];
      end

      default: begin
        state_s     = IDLE;
        grant_s     = 2'b00;
        busy_s      = 1'b0;
        remaining_s = CNT_ZERO;
        prescaler_s = PS_ZERO;
      end
    endcase
  end

  assign grant     = grant_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign remaining = remaining_r;
  assign unit_tick = unit_tick_r;

endmodule

// File: doc/shared_timer_arbiter.md
Name: shared_timer_arbiter

Overview:
Controller that shares one prescaled countdown timer between two requesters on the system clock (1 kHz in the miniproject).
- Arbitrates round-robin and latches the winner's unit count.
- Runs a prescaler that divides the clock by PRESCALE into unit ticks (1 Hz by default).
- Counts the latched units down, then pulses a per-requester done.
- Sits between the front-end control FSMs (stopwatch, alarm) and the divided-time base.

Parameters:
WIDTH, 16, width of requested unit count and remaining-count output
PRESCALE, 1000, clock cycles per unit tick (1000 gives 1 Hz from 1 kHz); must be >= 2
PW, 10, prescaler counter width; must satisfy 2**PW >= PRESCALE

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  2  level request per requester (bit 0 = requester 0)
count0  in  WIDTH  units requested by requester 0, sampled only at grant
count1  in  WIDTH  units requested by requester 1, sampled only at grant
cancel  in  2  per-requester abort; only the owner's bit has effect
grant  out  2  one-hot current owner; 00 when idle
busy  out  1  high while timer is owned (RUN or DONE)
done  out  2  one-cycle completion pulse to the owner
remaining  out  WIDTH  units left in the current countdown
unit_tick  out  1  one-cycle pulse per prescaler wrap while RUN

Behaviour:
- All outputs are registered.
- Reset (sampled high at an edge): state=IDLE, grant=00, busy=0, done=00, remaining=0, unit_tick=0, prescaler=0, last_served=1 (requester 0 wins first contention). Reset has priority over every other input, including mid-RUN; no done pulse is issued on reset.
- FSM states: IDLE, RUN, DONE.
- IDLE, no req: hold; all outputs 0.
- IDLE, any req bit high at edge E:
  - Winner = sole requester; or, if both request, the one != last_served.
  - At E: grant=onehot(winner), busy=1, remaining=count_winner, prescaler=0.
  - Next state: RUN if count_winner != 0; DONE if count_winner == 0.
- RUN:
  - prescaler increments every cycle.
  - When prescaler == PRESCALE-1 at an edge: prescaler=0, remaining=remaining-1, unit_tick=1 for the following cycle; otherwise unit_tick=0.
  - When that decrement takes remaining from 1 to 0, the same edge moves the state to DONE.
- DONE (exactly one cycle): done[owner]=1, grant and busy still asserted.
  - Next edge: state=IDLE, grant=00, busy=0, done=00, last_served=owner.
  - New arbitration is evaluated in the IDLE cycle. Earliest regrant is two edges after DONE is entered.
- Cancel: in RUN, cancel[owner]=1 at an edge:
  - state=IDLE, grant=00, busy=0, remaining=0, prescaler=0, unit_tick=0, last_served=owner; no done pulse.
  - cancel of the non-owner, or cancel in IDLE or DONE, is ignored.
  - Cancel coinciding with the final decrement edge: cancel wins, no done pulse.
- req or count changes during RUN/DONE are ignored; the count is latched at grant. The owner's req may stay high and is re-arbitrated normally (round-robin prevents starvation).
- Latency for a grant at edge G with count N >= 1:
  - unit_tick pulses in the cycles after edges G+k*PRESCALE, k = 1..N.
  - DONE with done pulse after edge G+N*PRESCALE.
  - grant clears at G+N*PRESCALE+1.
- Arithmetic: remaining never decrements below 0. Prescaler wraps only at PRESCALE-1. Counts are unsigned; max count 2**WIDTH-1 is legal.

Test Plan:
(PRESCALE=4, WIDTH=8 for simulation.)
1. Hold reset 3 cycles with req=11 -> grant=00, busy=0, done=00, remaining=0, unit_tick=0 throughout; first grant only after reset drops.
2. req=01, count0=3 at edge G -> grant=01, remaining=3 after G; unit_tick pulses after G+4, G+8, G+12 with remaining 2,1,0; done=01 for the cycle after G+12; grant=00 after G+13.
3. req=11 held, count0=count1=1 from reset -> requester 0 granted first; done[0] after G+4; requester 1 granted at G+6 (IDLE cycle between); then requester 0 again.
4. req=10, count1=0 -> grant=10 and done=10 in the same cycle after grant edge; no unit_tick; grant=00 one edge later.
5. Requester 0 running count0=5; cancel=10 at remaining=3 -> no effect. cancel=01 at remaining=2 -> grant=00, busy=0, remaining=0 next edge, done never pulses.
6. Reset asserted for one edge mid-RUN (remaining=4) -> all outputs zero next edge. Then req=11 -> requester 0 wins (last_served reset to 1).
